// File: rtl/samul_div_seq.sv
// ---------------------------------------------------------------------------
// samul_div_seq
// Sequential signed integer divider using sign-magnitude restoring division,
// one quotient bit per clock. Operands are converted to magnitudes when the
// request is accepted, divided unsigned, and the signs are applied in a final
// cycle before the result is registered.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   start        request, only honoured while idle
//   a, b         signed dividend / divisor, sampled with start
//   busy         high while an operation is in progress
//   done         one-cycle pulse when quotient/remainder/div_by_zero update
//   quotient     signed quotient, truncated toward zero
//   remainder    signed remainder, carries the sign of the dividend
//   div_by_zero  set together with done when the divisor was zero
// ---------------------------------------------------------------------------
module samul_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_SIGN = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, trial;

  // The most negative value negates to itself, which read unsigned is the
  // correct magnitude 2^(WIDTH-1).
  assign a_mag = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign b_mag = b[WIDTH-1] ? (~b + 1'b1) : b;

  // The partial remainder is always below the divisor, so after shifting it
  // fits in WIDTH+1 bits and the trial difference's top bit is its sign.
  assign shifted = {rem_q, dvd_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_q};

  always_comb begin
    state_d  = state_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    dz_d     = dz_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    quot_d   = quot_q;
    rmd_d    = rmd_q;
    dbz_d    = dbz_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sign_a_d = a[WIDTH-1];
          sign_b_d = b[WIDTH-1];
          dvs_d    = b_mag;
          rem_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          // On a zero divisor the raw dividend is kept so it can be
          // returned unchanged as the remainder.
          if (b == '0) begin
            dz_d    = 1'b1;
            dvd_d   = a;
            state_d = ST_SIGN;
          end else begin
            dz_d    = 1'b0;
            dvd_d   = a_mag;
            state_d = ST_CALC;
          end
        end
      end

      ST_CALC: begin
        // Quotient bits enter the dividend register from the bottom as the
        // dividend bits leave from the top.
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = ST_SIGN;
        end
      end

      ST_SIGN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
        if (dz_q) begin
          quot_d = '1;
          rmd_d  = dvd_q;
          dbz_d  = 1'b1;
        end else begin
          quot_d = (sign_a_q ^ sign_b_q) ? (~dvd_q + 1'b1) : dvd_q;
          rmd_d  = sign_a_q ? (~rem_q + 1'b1) : rem_q;
          dbz_d  = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      dz_q     <= 1'b0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      quot_q   <= '0;
      rmd_q    <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      dz_q     <= dz_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      quot_q   <= quot_d;
      rmd_q    <= rmd_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_samul_div_seq.sv
// ---------------------------------------------------------------------------
// tb_samul_div_seq
// Scoreboard bench for samul_div_seq (WIDTH=32). Each accepted request pushes
// its expected quotient/remainder/div_by_zero and the cycle in which done must
// appear; a monitor pops and compares on every done pulse.
// ---------------------------------------------------------------------------
module tb_samul_div_seq;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           done_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc        = 0;
  int   pushed     = 0;
  int   popped     = 0;
  int   vectors    = 0;
  int   miscompare = 0;

  samul_div_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Free-running clock with a cycle counter used for latency checks.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference: plain signed arithmetic on 64-bit values, truncated to W bits,
  // so the most-negative / -1 case wraps naturally.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input int done_cyc);
    exp_t   e;
    longint la;
    longint lb;
    la = longint'($signed(av));
    lb = longint'($signed(bv));
    e.done_cyc = done_cyc;
    if (bv == '0) begin
      e.q  = '1;
      e.r  = av;
      e.dz = 1'b1;
    end else begin
      e.q  = W'(la / lb);
      e.r  = W'(la % lb);
      e.dz = 1'b0;
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] act,
                             input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompare++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompare++;
        $display("[TB] FAIL unexpected_done: got done=1, expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        checkOutput("quotient",    quotient,            e.q);
        checkOutput("remainder",   remainder,           e.r);
        checkOutput("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dz});
        checkOutput("latency",     W'(cyc),             W'(e.done_cyc));
        checkOutput("busy_at_done", {31'b0, busy},      32'd0);
        popped++;
      end
    end
  end

  // Called at a falling edge; the request is sampled at the next rising edge.
  // Normal ops finish W+1 edges after that, zero-divisor ops one edge after.
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                               input bit hold);
    a     = av;
    b     = bv;
    start = 1'b1;
    sb_q.push_back(model(av, bv, cyc + 1 + ((bv == '0) ? 1 : W + 1)));
    pushed++;
    @(negedge clk);
    if (!hold) start = 1'b0;
    a = $urandom;
    b = $urandom;
    #1;
    for (int i = 0; i < 60 && popped < pushed; i++) begin
      @(negedge clk);
      #1;
    end
    if (popped < pushed) begin
      vectors++;
      miscompare++;
      $display("[TB] FAIL timeout: got no done, expected done for a=%h b=%h", av, bv);
      sb_q.delete();
      popped = pushed;
    end
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy",      {31'b0, busy},        32'd0);
    checkOutput("reset_done",      {31'b0, done},        32'd0);
    checkOutput("reset_quotient",  quotient,             32'd0);
    checkOutput("reset_remainder", remainder,            32'd0);
    checkOutput("reset_dbz",       {31'b0, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed sign and boundary cases.
    applyStimulus(32'd100,       32'd7,         1'b0);
    applyStimulus(-32'sd100,     32'd7,         1'b0);
    applyStimulus(32'd100,       -32'sd7,       1'b0);
    applyStimulus(-32'sd100,     -32'sd7,       1'b0);
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(32'h8000_0000, 32'd1,         1'b0);
    applyStimulus(32'd7,         32'd100,       1'b0);
    applyStimulus(32'd5,         32'd0,         1'b0);
    applyStimulus(32'd5,         32'd1,         1'b0);

    // Extra start pulses during an active op must not be taken.
    a     = 32'd1000;
    b     = 32'd10;
    start = 1'b1;
    sb_q.push_back(model(32'd1000, 32'd10, cyc + 1 + W + 1));
    pushed++;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("busy_mid_op", {31'b0, busy}, 32'd1);
    start = 1'b1;
    a     = 32'd7;
    b     = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    start = 1'b1;
    a     = 32'd1;
    b     = 32'd0;
    @(negedge clk);
    start = 1'b0;
    #1;
    for (int i = 0; i < 60 && popped < pushed; i++) begin
      @(negedge clk);
      #1;
    end
    if (popped < pushed) begin
      vectors++;
      miscompare++;
      $display("[TB] FAIL timeout: got no done, expected done for 1000/10");
      sb_q.delete();
      popped = pushed;
    end
    repeat (40) @(negedge clk);

    // Start held high: each op begins in the idle cycle after the previous done.
    applyStimulus(32'd81,          32'd9,    1'b1);
    applyStimulus(-32'sd12345,     32'd0,    1'b1);
    applyStimulus(32'h7FFF_FFFF,   -32'sd2,  1'b1);
    start = 1'b0;
    repeat (3) @(negedge clk);

    // Reset in the middle of a calculation abandons it silently.
    applyStimulus(32'd100, 32'd7, 1'b0);
    a     = 32'd1000;
    b     = 32'd10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("midrst_busy",      {31'b0, busy}, 32'd0);
    checkOutput("midrst_done",      {31'b0, done}, 32'd0);
    checkOutput("midrst_quotient",  quotient,      32'd0);
    checkOutput("midrst_remainder", remainder,     32'd0);
    repeat (40) @(negedge clk);
    applyStimulus(32'd9, 32'd2, 1'b0);

    // Randomised operands with extra weight on zero, small and extreme values.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       ra = 32'h8000_0000;
        1:       ra = $urandom_range(0, 1000);
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = $urandom_range(1, 50);
        3:       rb = -$urandom_range(1, 50);
        default: rb = $urandom;
      endcase
      applyStimulus(ra, rb, ($urandom_range(0, 3) == 0));
      start = 1'b0;
    end

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompare);
    $finish;
  end

endmodule
